// File: rtl/servo_driver.sv
// Dual-channel hobby-servo pulse generator. A shared free-running timebase defines the
// frame; each channel emits one high pulse per frame whose length is picked at the wrap.
module servo_driver #(
  parameter int unsigned PERIOD_COUNT = 2000000,
  parameter int unsigned PULSE_FWD    = 200000,
  parameter int unsigned PULSE_REV    = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor_l_reset,
  input  logic        motor_l_direction,
  input  logic        motor_r_reset,
  input  logic        motor_r_direction,
  output logic [20:0] count_out,
  output logic        period_start,
  output logic        pwm_l,
  output logic        pwm_r
);

  localparam int unsigned NumCh     = 2;
  localparam logic [20:0] LastCount = 21'(PERIOD_COUNT - 1);
  localparam logic [20:0] LenFwd    = 21'(PULSE_FWD);
  localparam logic [20:0] LenRev    = 21'(PULSE_REV);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} ch_state_e;

  logic [20:0] count_q, count_d;
  logic        wrap;
  logic        period_start_q;

  // Index 0 is the left channel, index 1 the right channel.
  logic [NumCh-1:0] dis_in, dir_in;
  logic [NumCh-1:0] dis_q;
  logic [NumCh-1:0] pwm_q, pwm_d;
  ch_state_e        state_q [NumCh];
  ch_state_e        state_d [NumCh];
  logic [20:0]      len_q   [NumCh];
  logic [20:0]      len_d   [NumCh];

  assign dis_in = {motor_r_reset, motor_l_reset};
  assign dir_in = {motor_r_direction, motor_l_direction};

  // Timebase next-state: count up, wrap to zero after the last count of the frame.
  always_comb begin
    wrap    = (count_q == LastCount);
    count_d = wrap ? 21'd0 : count_q + 21'd1;
  end

  // Timebase and frame strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= 21'd0;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_start_q <= wrap;
    end
  end

  // Per-channel FSM next-state. The wrap decision uses the live disable input, while a
  // mid-pulse disable acts through the sampled copy dis_q.
  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
      if (wrap) begin
        if (dis_in[i]) begin
          state_d[i] = StIdle;
        end else begin
          state_d[i] = StHigh;
          len_d[i]   = dir_in[i] ? LenFwd : LenRev;
        end
      end else begin
        unique case (state_q[i])
          StHigh: begin
            if (dis_q[i]) begin
              state_d[i] = StIdle;
            end else if (count_q == len_q[i] - 21'd1) begin
              state_d[i] = StLow;
            end
          end
          StIdle, StLow: ;
          default: state_d[i] = StIdle;
        endcase
      end
      pwm_d[i] = (state_d[i] == StHigh);
    end
  end

  // Per-channel state, latched pulse length, registered output and disable sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= StIdle;
        len_q[i]   <= LenRev;
      end
      pwm_q <= '0;
      dis_q <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
      end
      pwm_q <= pwm_d;
      dis_q <= dis_in;
    end
  end

  assign count_out    = count_q;
  assign period_start = period_start_q;
  assign pwm_l        = pwm_q[0];
  assign pwm_r        = pwm_q[1];

endmodule

// File: tb/tb_servo_driver.sv
// Self-checking bench for servo_driver with a 20-cycle frame and 4/2-cycle pulses.
module tb_servo_driver;

  localparam int unsigned Period = 20;
  localparam int unsigned Fwd    = 4;
  localparam int unsigned Rev    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        motor_l_reset = 1'b1;
  logic        motor_l_direction = 1'b0;
  logic        motor_r_reset = 1'b1;
  logic        motor_r_direction = 1'b0;
  logic [20:0] count_out;
  logic        period_start;
  logic        pwm_l;
  logic        pwm_r;

  int checks = 0;
  int failures = 0;

  servo_driver #(
    .PERIOD_COUNT(Period),
    .PULSE_FWD   (Fwd),
    .PULSE_REV   (Rev)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .motor_l_reset    (motor_l_reset),
    .motor_l_direction(motor_l_direction),
    .motor_r_reset    (motor_r_reset),
    .motor_r_direction(motor_r_direction),
    .count_out        (count_out),
    .period_start     (period_start),
    .pwm_l            (pwm_l),
    .pwm_r            (pwm_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance negedge by negedge until count_out reaches v, with a bounded budget.
  task automatic wait_count(input logic [20:0] v);
    int n = 0;
    while (count_out !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (count_out !== v) chk("align_timeout", 32'(count_out), 32'(v));
  endtask

  typedef struct {
    logic l_dis;
    logic l_dir;
    logic r_dis;
    logic r_dir;
    int   wl;
    int   wr;
  } vec_t;

  vec_t vecs [6];

  // Reference model state: frame position, per-channel enable, length and kill point.
  int m_cnt;
  int m_ps;
  int m_en   [2];
  int m_len  [2];
  int m_kill [2];

  function automatic int model_pwm(input int c);
    if (m_en[c] == 0) return 0;
    if (m_cnt >= m_len[c]) return 0;
    if (m_kill[c] >= 0 && m_cnt >= m_kill[c] + 2) return 0;
    return 1;
  endfunction

  initial begin
    int wl;
    int wr;
    int bad_l;
    int bad_r;
    int seq [20];

    vecs[0] = '{l_dis: 1, l_dir: 0, r_dis: 1, r_dir: 0, wl: 0, wr: 0};
    vecs[1] = '{l_dis: 0, l_dir: 1, r_dis: 0, r_dir: 0, wl: 4, wr: 2};
    vecs[2] = '{l_dis: 0, l_dir: 0, r_dis: 0, r_dir: 1, wl: 2, wr: 4};
    vecs[3] = '{l_dis: 0, l_dir: 1, r_dis: 1, r_dir: 1, wl: 4, wr: 0};
    vecs[4] = '{l_dis: 1, l_dir: 1, r_dis: 0, r_dir: 0, wl: 0, wr: 2};
    vecs[5] = '{l_dis: 0, l_dir: 0, r_dis: 0, r_dir: 0, wl: 2, wr: 2};

    // Held in reset for a few cycles.
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count_out), 0);
    chk("rst_period_start", 32'(period_start), 0);
    chk("rst_pwm_l", 32'(pwm_l), 0);
    chk("rst_pwm_r", 32'(pwm_r), 0);
    reset = 1'b0;

    // Both channels disabled for three frames.
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      chk($sformatf("idle_count t%0d", i), 32'(count_out), 32'(i % Period));
      chk($sformatf("idle_ps t%0d", i), 32'(period_start), 32'((i % Period) == 0));
      chk($sformatf("idle_pwm t%0d", i), 32'({pwm_l, pwm_r}), 0);
    end

    // Table: inputs presented before the wrap, then one full frame measured.
    for (int v = 0; v < 6; v++) begin
      wait_count(21'(Period - 1));
      motor_l_reset     = vecs[v].l_dis;
      motor_l_direction = vecs[v].l_dir;
      motor_r_reset     = vecs[v].r_dis;
      motor_r_direction = vecs[v].r_dir;
      wl = 0; wr = 0; bad_l = 0; bad_r = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == 0) begin
          chk($sformatf("vec%0d start_ps", v), 32'(period_start), 1);
          chk($sformatf("vec%0d start_pair", v), 32'({pwm_l, pwm_r}),
              32'({vecs[v].wl > 0, vecs[v].wr > 0}));
        end
        wl += int'(pwm_l);
        wr += int'(pwm_r);
        if (pwm_l !== (k < vecs[v].wl)) bad_l++;
        if (pwm_r !== (k < vecs[v].wr)) bad_r++;
      end
      chk($sformatf("vec%0d width_l", v), 32'(wl), 32'(vecs[v].wl));
      chk($sformatf("vec%0d width_r", v), 32'(wr), 32'(vecs[v].wr));
      chk($sformatf("vec%0d shape_l", v), 32'(bad_l), 0);
      chk($sformatf("vec%0d shape_r", v), 32'(bad_r), 0);
    end

    // Direction flip mid-pulse only affects the following frame.
    wait_count(21'(Period - 1));
    motor_l_reset = 1'b0; motor_l_direction = 1'b1;
    motor_r_reset = 1'b1;
    wl = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wl += int'(pwm_l);
      if (k == 2) motor_l_direction = 1'b0;
    end
    chk("dirflip cur_width", 32'(wl), 4);
    wl = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wl += int'(pwm_l);
    end
    chk("dirflip next_width", 32'(wl), 2);

    // Channel disable mid-pulse, re-enable later in the frame.
    wait_count(21'(Period - 1));
    motor_l_reset = 1'b0; motor_l_direction = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seq[k] = int'(pwm_l);
      if (k == 1) motor_l_reset = 1'b1;
      if (k == 10) motor_l_reset = 1'b0;
    end
    chk("kill c2_high", 32'(seq[2]), 1);
    chk("kill c3_low", 32'(seq[3]), 0);
    wl = 0;
    for (int k = 0; k < 20; k++) wl += seq[k];
    chk("kill width", 32'(wl), 3);
    wl = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) chk("kill resume_c0", 32'(pwm_l), 1);
      wl += int'(pwm_l);
    end
    chk("kill resume_width", 32'(wl), 4);

    // Right disable present only at the wrap edge.
    wait_count(21'(Period - 1));
    motor_l_reset = 1'b0; motor_l_direction = 1'b1;
    motor_r_reset = 1'b1; motor_r_direction = 1'b1;
    wl = 0; wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) motor_r_reset = 1'b0;
      wl += int'(pwm_l);
      wr += int'(pwm_r);
    end
    chk("wrapdis width_l", 32'(wl), 4);
    chk("wrapdis width_r", 32'(wr), 0);
    wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wr += int'(pwm_r);
    end
    chk("wrapdis next_width_r", 32'(wr), 4);

    // Asynchronous reset in the middle of a pulse.
    wait_count(21'd2);
    chk("areset pre_pwm", 32'({pwm_l, pwm_r}), 32'(2'b11));
    #2 reset = 1'b1;
    #1;
    chk("areset count", 32'(count_out), 0);
    chk("areset ps", 32'(period_start), 0);
    chk("areset pwm", 32'({pwm_l, pwm_r}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the frame-level model.
    m_cnt = 0; m_ps = 0;
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_len[c] = Rev; m_kill[c] = -1;
    end
    for (int i = 0; i < 600; i++) begin
      chk($sformatf("rnd_count i%0d", i), 32'(count_out), 32'(m_cnt));
      chk($sformatf("rnd_ps i%0d", i), 32'(period_start), 32'(m_ps));
      chk($sformatf("rnd_pwm_l i%0d", i), 32'(pwm_l), 32'(model_pwm(0)));
      chk($sformatf("rnd_pwm_r i%0d", i), 32'(pwm_r), 32'(model_pwm(1)));
      if ($urandom_range(0, 11) == 0) motor_l_reset = ~motor_l_reset;
      if ($urandom_range(0, 11) == 0) motor_r_reset = ~motor_r_reset;
      if ($urandom_range(0, 5) == 0) motor_l_direction = ~motor_l_direction;
      if ($urandom_range(0, 5) == 0) motor_r_direction = ~motor_r_direction;
      @(posedge clk);
      if (m_cnt == Period - 1) begin
        m_cnt = 0;
        m_ps  = 1;
        m_en[0] = int'(!motor_l_reset);
        m_en[1] = int'(!motor_r_reset);
        m_len[0] = motor_l_direction ? Fwd : Rev;
        m_len[1] = motor_r_direction ? Fwd : Rev;
        m_kill[0] = -1;
        m_kill[1] = -1;
      end else begin
        if (motor_l_reset && m_kill[0] < 0) m_kill[0] = m_cnt;
        if (motor_r_reset && m_kill[1] < 0) m_kill[1] = m_cnt;
        m_cnt++;
        m_ps = 0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_driver.md
SERVO_DRIVER -- requirements
Module: servo_driver

Interface
REQ-001 The block SHALL have parameter PERIOD_COUNT, default 2000000, meaning timebase period in clk cycles (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter PULSE_FWD, default 200000, meaning high-pulse length in cycles when direction=1 (2 ms).
REQ-003 The block SHALL have parameter PULSE_REV, default 100000, meaning high-pulse length in cycles when direction=0 (1 ms).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port motor_l_reset, input, 1 bit: left channel disable (1 = no pulses).
REQ-007 The block SHALL have port motor_l_direction, input, 1 bit: left pulse length select.
REQ-008 The block SHALL have port motor_r_reset, input, 1 bit: right channel disable.
REQ-009 The block SHALL have port motor_r_direction, input, 1 bit: right pulse length select.
REQ-010 The block SHALL have port count_out, output, 21 bits: current timebase count.
REQ-011 The block SHALL have port period_start, output, 1 bit: one-cycle strobe marking count_out = 0 of a new period.
REQ-012 The block SHALL have port pwm_l, output, 1 bit: left servo control pulse.
REQ-013 The block SHALL have port pwm_r, output, 1 bit: right servo control pulse.

Function
REQ-014 Timebase: count SHALL increment by 1 per cycle; when count = PERIOD_COUNT-1 it SHALL wrap to 0 at the next edge; no other values.
REQ-015 period_start SHALL be registered, 1 exactly in cycles where count_out = 0 reached by wrap, else 0.
REQ-016 Each channel SHALL run an independent FSM with states IDLE, HIGH, LOW; pwm_x SHALL be registered and equal 1 only in HIGH.
REQ-017 At the wrap edge (count = PERIOD_COUNT-1), each channel SHALL sample its reset/direction: reset=0 -> HIGH with latched length (PULSE_FWD if direction=1, else PULSE_REV); reset=1 -> IDLE.
REQ-018 HIGH -> LOW at the edge where count = latched length-1, so pwm_x is high for exactly latched-length cycles (count_out 0..len-1).
REQ-019 LOW and IDLE SHALL hold until the next wrap edge, then re-evaluate per REQ-017.
REQ-020 Direction changes mid-period SHALL be ignored until the next wrap edge; latched length is constant within a period.
REQ-021 motor_x_reset rising while in HIGH SHALL force IDLE at the next edge (pwm_x low one cycle later); deassertion takes effect only at the next wrap edge.
REQ-022 Simultaneous wrap and motor_x_reset=1 SHALL yield IDLE (disable wins).
REQ-023 Left and right channels SHALL share the timebase; pulses start on the same cycle.
REQ-024 Parameters SHALL satisfy PULSE_REV, PULSE_FWD >= 1 and < PERIOD_COUNT <= 2^21; behaviour outside is undefined.

Reset
REQ-025 While reset=1 (asynchronously, regardless of clk): count_out=0, period_start=0, pwm_l=0, pwm_r=0, both FSMs IDLE, latched lengths = PULSE_REV.
REQ-026 After reset release, count SHALL increment from 0; the first pulse opportunity is the first wrap (PERIOD_COUNT cycles later); reset mid-pulse SHALL drop pwm_x immediately.

Verification (PERIOD_COUNT=20, PULSE_FWD=4, PULSE_REV=2)
REQ-027 Reset release, both channels disabled, 60 cycles -> count_out 0..19 repeating, period_start high at each count 0 after wrap, pwm_l=pwm_r=0 throughout.
REQ-028 l_reset=0, l_dir=1, r_reset=0, r_dir=0 -> per period pwm_l high 4 cycles (count 0..3), pwm_r high 2 cycles (count 0..1), both rising on same cycle.
REQ-029 l_dir toggled 1->0 at count 2 of a forward pulse -> current pulse stays 4 cycles; next period 2 cycles.
REQ-030 motor_l_reset asserted at count 1 of a 4-cycle pulse -> pwm_l low from count 3 onward (IDLE); deasserted at count 10 -> next pulse at next count 0.
REQ-031 reset asserted asynchronously between edges at count 2 with pwm high -> pwm_l, pwm_r, count_out, period_start all 0 immediately, before next clk edge.
REQ-032 motor_r_reset=1 exactly on wrap edge, r_dir=1 -> pwm_r stays 0 that period; pwm_l unaffected.
